// File: rtl/exp3_detector_jogada_pkg.sv
// Shared state codes, debounce default and one-hot helper for the jogada detector.
package exp3_detector_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000;

  typedef logic [3:0] estado_t;

  localparam estado_t ST_OCIOSO        = 4'h0;
  localparam estado_t ST_ESTABILIZANDO = 4'h1;
  localparam estado_t ST_REGISTRA      = 4'h2;
  localparam estado_t ST_ESPERA_SOLTAR = 4'h3;
  localparam estado_t ST_ERRO          = 4'hE;

  // Callers zero-extend their code to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/exp3_detector_jogada_if.sv
// Button-side and consumer-side signals of the jogada detector.
// Carries erro_multipla only when EXP3_DETECTOR_ONEHOT_EN is defined.
interface exp3_detector_jogada_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] botoes;
  logic [WIDTH-1:0] chaves_reg;
  logic             jogada;
  logic             botao_ativo;
  logic [3:0]       db_estado;
`ifdef EXP3_DETECTOR_ONEHOT_EN
  logic             erro_multipla;
`endif

  modport master (
    output botoes,
    input  chaves_reg, jogada, botao_ativo, db_estado
`ifdef EXP3_DETECTOR_ONEHOT_EN
    , input erro_multipla
`endif
  );

  modport slave (
    input  botoes,
    output chaves_reg, jogada, botao_ativo, db_estado
`ifdef EXP3_DETECTOR_ONEHOT_EN
    , output erro_multipla
`endif
  );
endinterface

// File: rtl/exp3_detector_jogada_sincronizador.sv
// WIDTH-bit two-flop synchronizer for asynchronous inputs (buttons, iniciar).
module exp3_sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] estagio1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estagio1 <= '0;
      q        <= '0;
    end else begin
      estagio1 <= d;
      q        <= estagio1;
    end
  end

endmodule

// File: rtl/exp3_detector_jogada.sv
// Button conditioner: synchronize, debounce press/release, latch code, strobe jogada.
// Optional EXP3_DETECTOR_ONEHOT_EN rejects multi-bit codes through the ERRO state.
module exp3_detector_jogada
  import exp3_detector_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  exp3_detector_jogada_if.slave bus
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] amostra;
  logic [WIDTH-1:0] chaves_q;
  logic [CW-1:0]    cnt;
  estado_t          estado;
  estado_t          estado_prox;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             amostra_ld;

  exp3_sincronizador #(.WIDTH(WIDTH)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (bus.botoes),
    .q     (sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= ST_OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    amostra_ld  = 1'b0;
    case (estado)
      ST_OCIOSO: begin
        if (sync != '0) begin
          estado_prox = ST_ESTABILIZANDO;
          amostra_ld  = 1'b1;
          cnt_clr     = 1'b1;
        end
      end
      ST_ESTABILIZANDO: begin
        if (sync == '0) begin
          estado_prox = ST_OCIOSO;
        end else if (sync != amostra) begin
          amostra_ld = 1'b1;
          cnt_clr    = 1'b1;
        end else if (cnt == CNT_FIM) begin
`ifdef EXP3_DETECTOR_ONEHOT_EN
          estado_prox = is_onehot(32'(amostra)) ? ST_REGISTRA : ST_ERRO;
`else
          estado_prox = ST_REGISTRA;
`endif
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_REGISTRA: begin
        estado_prox = ST_ESPERA_SOLTAR;
        cnt_clr     = 1'b1;
      end
`ifdef EXP3_DETECTOR_ONEHOT_EN
      ST_ERRO: begin
        estado_prox = ST_ESPERA_SOLTAR;
        cnt_clr     = 1'b1;
      end
`endif
      ST_ESPERA_SOLTAR: begin
        // Any activity while held restarts the release window; codes are ignored.
        if (sync != '0)          cnt_clr     = 1'b1;
        else if (cnt == CNT_FIM) estado_prox = ST_OCIOSO;
        else                     cnt_inc     = 1'b1;
      end
      default: begin
        estado_prox = ST_OCIOSO;
        cnt_clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      amostra  <= '0;
      chaves_q <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (amostra_ld)   amostra <= sync;
      // Latched on the edge leaving REGISTRA, i.e. as jogada falls.
      if (estado == ST_REGISTRA) chaves_q <= amostra;
    end
  end

  always_comb begin
    bus.jogada        = (estado == ST_REGISTRA);
    bus.botao_ativo   = (estado != ST_OCIOSO);
    bus.db_estado     = estado;
    bus.chaves_reg    = chaves_q;
`ifdef EXP3_DETECTOR_ONEHOT_EN
    bus.erro_multipla = (estado == ST_ERRO);
`endif
  end

endmodule

// File: tb/tb_exp3_detector_jogada.sv
// Self-checking bench for exp3_detector_jogada with a run-length reference model.
module tb_exp3_detector_jogada;

  localparam int W = 4;
  localparam int D = 4;
`ifdef EXP3_DETECTOR_ONEHOT_EN
  localparam bit ONEHOT = 1'b1;
`else
  localparam bit ONEHOT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exp3_detector_jogada_if #(.WIDTH(W)) bus();

  exp3_detector_jogada #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase plus run lengths of identical raw samples seen after the 2-cycle sync delay.
  typedef enum int {M_IDLE, M_PRESS, M_ACCEPT, M_REJECT, M_HOLD} fase_t;
  fase_t      m_fase;
  logic [3:0] m_code, m_chaves, m_h1, m_h2;
  int         m_run, m_zrun;

  task automatic model_reset();
    m_fase = M_IDLE; m_code = '0; m_chaves = '0; m_h1 = '0; m_h2 = '0;
    m_run = 0; m_zrun = 0;
  endtask

  task automatic model_edge(input logic [3:0] v);
    case (m_fase)
      M_IDLE:
        if (v != 0) begin m_fase = M_PRESS; m_code = v; m_run = 1; end
      M_PRESS:
        if (v == 0) m_fase = M_IDLE;
        else if (v != m_code) begin m_code = v; m_run = 1; end
        else begin
          m_run++;
          if (m_run == D + 1)
            m_fase = (ONEHOT && $countones(m_code) != 1) ? M_REJECT : M_ACCEPT;
        end
      M_ACCEPT: begin m_chaves = m_code; m_fase = M_HOLD; m_zrun = 0; end
      M_REJECT: begin m_fase = M_HOLD; m_zrun = 0; end
      M_HOLD:
        if (v != 0) m_zrun = 0;
        else begin m_zrun++; if (m_zrun == D) m_fase = M_IDLE; end
      default: m_fase = M_IDLE;
    endcase
  endtask

  function automatic logic [10:0] exp_vec();
    logic [3:0] db;
    case (m_fase)
      M_IDLE:   db = 4'h0;
      M_PRESS:  db = 4'h1;
      M_ACCEPT: db = 4'h2;
      M_HOLD:   db = 4'h3;
      default:  db = 4'hE;
    endcase
    return {m_fase == M_REJECT, m_fase == M_ACCEPT, m_fase != M_IDLE, db, m_chaves};
  endfunction

  function automatic logic [10:0] obs_vec();
    logic e;
`ifdef EXP3_DETECTOR_ONEHOT_EN
    e = bus.erro_multipla;
`else
    e = 1'b0;
`endif
    return {e, bus.jogada, bus.botao_ativo, bus.db_estado, bus.chaves_reg};
  endfunction

  task automatic step(input logic [3:0] b);
    bus.botoes = b;
    @(posedge clock);
    model_edge(m_h2);
    m_h2 = m_h1;
    m_h1 = b;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.botoes = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle_run();
    for (int i = 0; i < D + 6; i++) step(4'b0000);
  endtask

  task automatic test_reset();
    bus.botoes = '0;
    model_reset();
    #1;
    n_tests++;
    if (obs_vec() !== 11'b0) begin
      n_fail++; $display("FAIL reset_values: got %b required %b", obs_vec(), 11'b0);
    end
  endtask

  task automatic test_press_basic();
    int first = 0;
    int seq[$];
    do_reset();
    seq.push_back(int'(bus.db_estado));
    for (int i = 1; i <= 12; i++) begin
      step(4'b0010);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL press_basic edge %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      if (bus.jogada === 1'b1 && first == 0) first = i;
      if (int'(bus.db_estado) != seq[$]) seq.push_back(int'(bus.db_estado));
      if (i == 8) begin
        n_tests++;
        if (bus.chaves_reg !== 4'b0010) begin
          n_fail++; $display("FAIL press_basic_chaves: got %b required %b", bus.chaves_reg, 4'b0010);
        end
      end
    end
    n_tests++;
    if (first != 7) begin
      n_fail++; $display("FAIL press_basic_latency: got edge %0d required edge 7", first);
    end
    n_tests++;
    if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3) begin
      n_fail++; $display("FAIL press_basic_db_seq: got %p required 0,1,2,3", seq);
    end
  endtask

  task automatic test_bounce();
    int jog = 0;
    idle_run();
    for (int i = 0; i < 11; i++) begin
      step(i < 3 ? 4'b0100 : 4'b0000);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bounce step %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      jog += int'(bus.jogada);
    end
    n_tests++;
    if (jog != 0 || bus.db_estado !== 4'h0 || bus.chaves_reg !== 4'b0010) begin
      n_fail++; $display("FAIL bounce_end: got jog=%0d db=%h chaves=%b required 0/0/0010",
                         jog, bus.db_estado, bus.chaves_reg);
    end
  endtask

  task automatic test_restart();
    int jog = 0;
    idle_run();
    for (int i = 0; i < 14; i++) begin
      step(i < 2 ? 4'b0001 : 4'b1000);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL restart step %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      jog += int'(bus.jogada);
    end
    n_tests++;
    if (jog != 1 || bus.chaves_reg !== 4'b1000) begin
      n_fail++; $display("FAIL restart_end: got jog=%0d chaves=%b required 1/1000", jog, bus.chaves_reg);
    end
  endtask

  task automatic test_release_glitch();
    logic [3:0] pat [$];
    int jog_glitch = 0, jog_new = 0;
    idle_run();
    for (int i = 0; i < 10; i++) pat.push_back(4'b0010);
    pat = {pat, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010,
           4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 12; i++) pat.push_back(4'b0100);
    foreach (pat[i]) begin
      step(pat[i]);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL release_glitch step %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      if (i >= 12 && i < 23) jog_glitch += int'(bus.jogada);
      if (i >= 23) jog_new += int'(bus.jogada);
    end
    n_tests++;
    if (jog_glitch != 0 || jog_new != 1 || bus.chaves_reg !== 4'b0100) begin
      n_fail++; $display("FAIL release_glitch_end: got glitch=%0d new=%0d chaves=%b required 0/1/0100",
                         jog_glitch, jog_new, bus.chaves_reg);
    end
  endtask

  task automatic test_async_reset();
    int jog = 0;
    idle_run();
    for (int i = 0; i < 4; i++) step(4'b0001);
    n_tests++;
    if (bus.db_estado !== 4'h1) begin
      n_fail++; $display("FAIL async_reset_pre: got db=%h required 1", bus.db_estado);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (obs_vec() !== 11'b0) begin
      n_fail++; $display("FAIL async_reset_immediate: got %b required %b", obs_vec(), 11'b0);
    end
    model_reset();
    bus.botoes = 4'b0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step(i < 10 ? 4'b0000 : 4'b0001);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL async_reset step %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      if (i < 10 && bus.jogada === 1'b1) jog += 100;
      if (i >= 10) jog += int'(bus.jogada);
    end
    n_tests++;
    if (jog != 1 || bus.chaves_reg !== 4'b0001) begin
      n_fail++; $display("FAIL async_reset_end: got jog=%0d chaves=%b required 1/0001", jog, bus.chaves_reg);
    end
  endtask

  task automatic test_multibit();
    int jog = 0, err = 0;
    bit saw_e_then_3 = 1'b0;
    logic [3:0] prev_db = 4'h0;
    idle_run();
    for (int i = 0; i < 14; i++) begin
      step(4'b0011);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL multibit step %0d: got %b required %b", i, obs_vec(), exp_vec());
      end
      jog += int'(bus.jogada);
      err += int'(obs_vec() >> 10);
      if (prev_db == 4'hE && bus.db_estado == 4'h3) saw_e_then_3 = 1'b1;
      prev_db = bus.db_estado;
    end
    n_tests++;
    if (ONEHOT) begin
      if (jog != 0 || err != 1 || !saw_e_then_3 || bus.chaves_reg !== 4'b0001) begin
        n_fail++; $display("FAIL multibit_onehot: got jog=%0d err=%0d e3=%0d chaves=%b required 0/1/1/0001",
                           jog, err, saw_e_then_3, bus.chaves_reg);
      end
    end else begin
      if (jog != 1 || err != 0 || bus.chaves_reg !== 4'b0011) begin
        n_fail++; $display("FAIL multibit_asis: got jog=%0d err=%0d chaves=%b required 1/0/0011",
                           jog, err, bus.chaves_reg);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] code;
    int len, r, k = 0;
    idle_run();
    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      code = 4'b0000;
      else if (r < 7) code = 4'(1 << $urandom_range(0, 3));
      else            code = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        step(code);
        k++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL random step %0d: got %b required %b", k, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_basic();
    test_bounce();
    test_restart();
    test_release_glitch();
    test_async_reset();
    test_multibit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp3_detector_jogada.md
Name: exp3_detector_jogada

Overview:
Input conditioner that sits directly upstream of the datapath's chaves input and the control unit's start logic.
- Synchronizes the 4 raw player buttons and debounces press and release.
- Emits a stable latched 4-bit code plus a one-cycle jogada strobe per physical press.
- Exposes a 4-bit state code suitable for a hexa7seg debug display.

Parameters:
- WIDTH, 4: number of button lines.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press or a release. Legal range is 2 or more; the bench uses 4.

Ports:
- clock, input, 1: system clock, all logic rising-edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- botoes, input, WIDTH: raw asynchronous buttons, active-high.
- chaves_reg, output, WIDTH: last accepted code; held until the next accepted press.
- jogada, output, 1: one-cycle pulse when a new code is accepted.
- botao_ativo, output, 1: high in every state except OCIOSO.
- db_estado, output, 4: current FSM state code.

Behaviour:
- Clocking and reset: one clock (clock); reset is asynchronous and active-high.
- Reset values:
  - chaves_reg=0, jogada=0, botao_ativo=0, db_estado=0.
  - Sync flops = 0, counter = 0, sample register = 0, FSM = OCIOSO.
  - Reset asserted mid-operation aborts any count immediately; no jogada is emitted.
- Synchronizer: two flip-flops per bit; the FSM sees only sync = second-stage output.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); never wraps, because it is cleared on every state entry and every restart.
- States and db_estado codes: OCIOSO=0x0, ESTABILIZANDO=0x1, REGISTRA=0x2, ESPERA_SOLTAR=0x3.
- OCIOSO:
  - sync != 0 → ESTABILIZANDO, with amostra <= sync and cnt <= 0.
- ESTABILIZANDO:
  - sync == 0 → OCIOSO (bounce rejected).
  - sync != amostra, nonzero → stay, amostra <= sync, cnt <= 0 (restart).
  - sync == amostra and cnt == DEBOUNCE_CYCLES-1 → REGISTRA.
  - sync == amostra otherwise → cnt++.
- REGISTRA (exactly one cycle):
  - jogada=1; chaves_reg <= amostra on the edge leaving the state.
  - Unconditionally → ESPERA_SOLTAR, cnt <= 0.
- ESPERA_SOLTAR:
  - sync != 0 → cnt <= 0; no new jogada regardless of code changes.
  - sync == 0 and cnt == DEBOUNCE_CYCLES-1 → OCIOSO.
  - sync == 0 otherwise → cnt++.
- Latency: with botoes stable from before rising edge 1, the FSM moves to REGISTRA on edge DEBOUNCE_CYCLES+3, so jogada is high for the cycle following that edge.
- Output timing: jogada is Moore (decoded from state) and glitch-free. chaves_reg updates on the same edge that deasserts jogada, so the consumer samples chaves_reg one cycle after jogada.
- Multiple-bit codes are accepted as-is unless the optional feature is compiled in.

Optional Feature:
Macro EXP3_DETECTOR_ONEHOT_EN.
- Defined:
  - Adds output erro_multipla (1 bit, reset 0) and state ERRO, code 0xE.
  - In ESTABILIZANDO, a completed count on a non-one-hot amostra → ERRO instead of REGISTRA.
  - ERRO lasts one cycle with erro_multipla=1, jogada=0 and chaves_reg unchanged, then → ESPERA_SOLTAR.
- Undefined: the port and state are absent; any nonzero stable code is registered.

Decomposition:
- Package exp3_detector_pkg holds:
  - state encodings as 4-bit localparams, including the ERRO code;
  - DEBOUNCE_CYCLES default;
  - a one-hot check function.
- Natural sub-module: exp3_sincronizador (WIDTH-parameterized two-flop synchronizer), reusable for iniciar.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then botoes=4'b0010 held from before edge 1 → jogada high only after edge 7. chaves_reg=4'b0010 after edge 8; botao_ativo=1; db_estado sequence 0,1,2,3.
2. botoes=4'b0100 pulsed for 3 cycles then 0 → no jogada; FSM returns to OCIOSO; chaves_reg unchanged.
3. Press 4'b0001, then switch to 4'b1000 after 2 stable cycles and hold → count restarts; a single jogada with chaves_reg=4'b1000.
4. Accepted press held, released with 2-cycle 0 glitches, then re-pressed → no second jogada until 4 consecutive zero cycles complete and a new full press qualifies.
5. Reset asserted asynchronously mid-ESTABILIZANDO → all outputs 0 immediately, before the next edge; no jogada after deassert unless a new full press occurs.
6. With EXP3_DETECTOR_ONEHOT_EN, botoes=4'b0011 held → erro_multipla pulses one cycle; db_estado=0xE then 0x3; jogada stays 0; chaves_reg unchanged.
